cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
- Multi-cycle fetch/decode/execute/writeback sequencer for the 8-bit CPU.
- Directly upstream of register_file: it drives the write port (write_enable/addr/data) and both read addresses, and consumes both read data.
- Holds PC, IR and Z/C flags, and contains the ALU.
- Fetches instruction bytes from instruction memory over a req/ready handshake.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- imem_req  out  1  fetch request; held high until imem_ready is seen.
- imem_addr  out  8  fetch address (= PC).
- imem_ready  in  1  imem_data valid this cycle; completes the request.
- imem_data  in  8  fetched byte.
- rf_we  out  1  register_file write_enable.
- rf_waddr  out  2  register_file write_addr.
- rf_wdata  out  8  register_file write_data.
- rf_raddr1  out  2  register_file read_addr1 (= IR[3:2], rd).
- rf_raddr2  out  2  register_file read_addr2 (= IR[1:0], rs).
- rf_rdata1  in  8  register_file read_data1 (combinational).
- rf_rdata2  in  8  register_file read_data2 (combinational).
- pc  out  8  current PC.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow flag.
- halted  out  1  high while in HALT state.

Behaviour:
- Instruction format: [7:4] opcode, [3:2] rd, [1:0] rs.
- Opcodes:
  - 0 NOP.
  - 1 MOV: rd<=rs.
  - 2 ADD: rd<=rd+rs.
  - 3 SUB: rd<=rd-rs.
  - 4 AND, 5 OR, 6 XOR.
  - 7 NOT: rd<=~rs.
  - 8 LDI: rd<=imm.
  - 9 JMP imm.
  - A JZ imm.
  - B JC imm.
  - F HALT.
  - C/D/E illegal.
- LDI/JMP/JZ/JC are 2-byte; the second byte (imm) is at PC+1.
- States: FETCH, DECODE, FETCH_IMM, EXEC, WB, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ready: IR<=imem_data, pc<=pc+1, ->DECODE.
  - Otherwise stay in FETCH with req held.
- DECODE:
  - 2-byte op ->FETCH_IMM.
  - HALT ->HALT.
  - NOP ->FETCH.
  - Else ->EXEC.
- FETCH_IMM: same handshake as FETCH; on ready: IMM<=imem_data, pc<=pc+1, ->EXEC.
- EXEC:
  - Compute result from rf_rdata1/rf_rdata2/IMM.
  - Load rf_wdata/rf_waddr=rd, set rf_we=1, ->WB.
  - Jumps instead update pc (taken: pc<=IMM) and go ->FETCH, never entering WB.
- WB:
  - rf_we high for exactly this one cycle; the write commits on the edge ending WB.
  - rf_we<=0, ->FETCH.
- HALT: terminal; halted=1, imem_req=0, rf_we=0; left only by reset.
- Flags, updated in EXEC:
  - ADD: C = 9th bit of rd+rs.
  - SUB: C=1 iff rd<rs (borrow), unsigned.
  - AND/OR/XOR/NOT: C<=0.
  - ALU ops set Z=(result==0).
  - MOV, LDI, NOP and jumps leave flags unchanged.
- Arithmetic is 8-bit modulo 256. PC wraps 8'hFF->8'h00, including when fetching the imm byte.
- Illegal opcodes execute as NOP (DECODE->FETCH).
- Latency with imem_ready tied high:
  - NOP = 2 cycles.
  - 1-byte ALU/MOV = 4 cycles (FETCH, DECODE, EXEC, WB).
  - LDI = 5 cycles.
  - JMP/JZ/JC = 4 cycles.
  - Each cycle imem_ready is low adds one cycle.
- Reset values:
  - state=FETCH, pc=RESET_PC, IR=0, IMM=0.
  - flag_z=0, flag_c=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - halted=0.
  - imem_req=0 during the reset cycle.
- Reset mid-operation:
  - Any in-flight fetch is abandoned; a late imem_ready is ignored until the new FETCH.
  - A pending WB is cancelled (rf_we=0), so no register write occurs.
- imem_req is never dropped before imem_ready.
- imem_addr is stable while imem_req is high.
- rf_raddr1/2 are always IR-derived and stable from DECODE through WB.

Optional Feature:
- ILLEGAL_TRAP_EN.
- Defined:
  - Opcodes C/D/E go DECODE->HALT.
  - Sticky output illegal_op (1 bit, reset 0) is set, and pc points past the offending byte.
- Undefined:
  - Illegal opcodes are NOPs.
  - No illegal_op port exists.

Test Plan:
- Reset, imem_ready=1, program {8'h84,8'h05 (LDI r1,5)}:
  - rf_we=1, waddr=1, wdata=8'h05 in cycle 5.
  - pc=8'h02 afterwards.
- r1=8'hF0, r2=8'h20, ADD r1,r2 (8'h26):
  - wdata=8'h10, flag_c=1, flag_z=0.
  - Then SUB r1,r1 (8'h35) -> wdata=0, Z=1, C=0.
- SUB r0,r1 with r0=3, r1=5 -> wdata=8'hFE, C=1.
  - Then JC 8'h40 -> next imem_addr=8'h40.
  - JZ 8'h40 with Z=0 -> falls through to pc+2.
- imem_ready held low 3 cycles during FETCH:
  - imem_req stays 1, imem_addr constant, no state advance.
  - Instruction completes 3 cycles later than the ready-tied case.
- Reset asserted in WB cycle of MOV:
  - No rf_we edge commits, pc=RESET_PC.
  - Next cycle FETCH with imem_req=1 at RESET_PC.
- HALT (8'hF0) -> halted=1, imem_req=0 forever.
  - With ILLEGAL_TRAP_EN defined, 8'hC0 -> halted=1, illegal_op=1.
  - Without it, 8'hC0 -> next fetch at pc+1.

Source files
------------

// File: rtl/cpu_control_unit_if.sv
// Bus bundle between cpu_control_unit and its instruction memory and register file.
// The master modport is the control unit's side and the slave modport is the memory/regfile side.
interface cpu_control_unit_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned REG_W  = 2;

  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_ready;
  logic [DATA_W-1:0] imem_data;
  logic              rf_we;
  logic [REG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [REG_W-1:0]  rf_raddr1;
  logic [REG_W-1:0]  rf_raddr2;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;

  modport master (
    output imem_req, imem_addr, rf_we, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2,
    input  imem_ready, imem_data, rf_rdata1, rf_rdata2
  );

  modport slave (
    input  imem_req, imem_addr, rf_we, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2,
    output imem_ready, imem_data, rf_rdata1, rf_rdata2
  );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 8-bit CPU (PC, IR, flags, ALU).
// Define ILLEGAL_TRAP_EN to make opcodes C/D/E halt the core and raise the sticky illegal_op output.
module cpu_control_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  cpu_control_unit_if.master bus,
  output logic [7:0]         pc,
  output logic               flag_z,
  output logic               flag_c,
  output logic               halted
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic               illegal_op
`endif
);
  localparam int unsigned DW = 8;
  localparam int unsigned RW = 2;

  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_FETCH_IMM = 3'd2;
  localparam logic [2:0] ST_EXEC      = 3'd3;
  localparam logic [2:0] ST_WB        = 3'd4;
  localparam logic [2:0] ST_HALT      = 3'd5;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JC   = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [RW-1:0] waddr_q, waddr_d;
  logic          we_q, we_d;
  logic          z_q, z_d;
  logic          c_q, c_d;
  logic          req_q, req_d;
  logic          halt_q, halt_d;
`ifdef ILLEGAL_TRAP_EN
  logic          ill_q, ill_d;
`endif

  logic [3:0]    opcode;
  logic [RW-1:0] rd, rs;
  logic [DW:0]   sum, diff;

  assign opcode = ir_q[7:4];
  assign rd     = ir_q[3:2];
  assign rs     = ir_q[1:0];

  // Reset gates the handshake and write strobe so nothing leaks out during a reset cycle.
  assign bus.imem_req  = req_q & ~reset;
  assign bus.imem_addr = pc_q;
  assign bus.rf_we     = we_q & ~reset;
  assign bus.rf_waddr  = waddr_q;
  assign bus.rf_wdata  = wdata_q;
  assign bus.rf_raddr1 = rd;
  assign bus.rf_raddr2 = rs;
  assign pc            = pc_q;
  assign flag_z        = z_q;
  assign flag_c        = c_q;
  assign halted        = halt_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_op    = ill_q;
`endif

  // Next-state, datapath and flag logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    we_d    = 1'b0;
    z_d     = z_q;
    c_d     = c_q;
`ifdef ILLEGAL_TRAP_EN
    ill_d   = ill_q;
`endif
    sum  = {1'b0, bus.rf_rdata1} + {1'b0, bus.rf_rdata2};
    diff = {1'b0, bus.rf_rdata1} - {1'b0, bus.rf_rdata2};

    case (state_q)
      ST_FETCH: begin
        if (bus.imem_ready) begin
          ir_d    = bus.imem_data;
          pc_d    = pc_q + DW'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_LDI, OP_JMP, OP_JZ, OP_JC: state_d = ST_FETCH_IMM;
          OP_HALT:                      state_d = ST_HALT;
          OP_NOP:                       state_d = ST_FETCH;
          4'hC, 4'hD, 4'hE: begin
`ifdef ILLEGAL_TRAP_EN
            state_d = ST_HALT;
            ill_d   = 1'b1;
`else
            state_d = ST_FETCH;
`endif
          end
          default:                      state_d = ST_EXEC;
        endcase
      end
      ST_FETCH_IMM: begin
        if (bus.imem_ready) begin
          imm_d   = bus.imem_data;
          pc_d    = pc_q + DW'(1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_WB;
        waddr_d = rd;
        we_d    = 1'b1;
        case (opcode)
          OP_MOV: wdata_d = bus.rf_rdata2;
          OP_LDI: wdata_d = imm_q;
          OP_ADD: begin wdata_d = sum[DW-1:0];  c_d = sum[DW];  end
          OP_SUB: begin wdata_d = diff[DW-1:0]; c_d = diff[DW]; end
          OP_AND: begin wdata_d = bus.rf_rdata1 & bus.rf_rdata2; c_d = 1'b0; end
          OP_OR:  begin wdata_d = bus.rf_rdata1 | bus.rf_rdata2; c_d = 1'b0; end
          OP_XOR: begin wdata_d = bus.rf_rdata1 ^ bus.rf_rdata2; c_d = 1'b0; end
          OP_NOT: begin wdata_d = ~bus.rf_rdata2;                c_d = 1'b0; end
          default: begin
            // Jumps bypass writeback entirely.
            we_d    = 1'b0;
            waddr_d = waddr_q;
            state_d = ST_FETCH;
            if ((opcode == OP_JMP) || ((opcode == OP_JZ) && z_q) || ((opcode == OP_JC) && c_q))
              pc_d = imm_q;
          end
        endcase
        if (opcode inside {[OP_ADD:OP_NOT]})
          z_d = (wdata_d == '0);
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase

    req_d  = (state_d == ST_FETCH) || (state_d == ST_FETCH_IMM);
    halt_d = (state_d == ST_HALT);
  end

  // State register; req resets high because reset lands in FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      imm_q   <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      req_q   <= 1'b1;
      halt_q  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      ill_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
      z_q     <= z_d;
      c_q     <= c_d;
      req_q   <= req_d;
      halt_q  <= halt_d;
`ifdef ILLEGAL_TRAP_EN
      ill_q   <= ill_d;
`endif
    end
  end
endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: directed programs plus random programs with random fetch stalls,
// checked cycle by cycle against an instruction-level ISA model.
module tb_cpu_control_unit;
  localparam logic [7:0] RST_PC = 8'h00;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pc;
  logic       flag_z, flag_c, halted;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  cpu_control_unit_if bus ();

  cpu_control_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .pc         (pc),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .halted     (halted)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal_op (illegal_op)
`endif
  );

  always #5 clk = ~clk;

  // Environment: instruction memory and register file.
  logic [7:0] imem   [256];
  logic [7:0] rf_mem [4];
  logic       ready_r;

  assign bus.imem_ready = ready_r;
  assign bus.imem_data  = imem[bus.imem_addr];
  assign bus.rf_rdata1  = rf_mem[bus.rf_raddr1];
  assign bus.rf_rdata2  = rf_mem[bus.rf_raddr2];

  always @(posedge clk) if (bus.rf_we) rf_mem[bus.rf_waddr] <= bus.rf_wdata;

  // ISA model state.
  logic [7:0] m_pc;
  bit         m_z, m_c;
  int         m_regs [4];

  int n_checks = 0;
  int n_fails  = 0;
  bit stop;
  logic [7:0] tmp_byte;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit trap_op(input logic [3:0] op);
    return TRAP_EN && (op inside {[4'hC:4'hE]});
  endfunction

  function automatic int pick_stall();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
  endfunction

  function automatic logic [7:0] rand_byte();
    logic [3:0] op;
    op = 4'($urandom_range(0, 14));
    if (trap_op(op)) op = 4'h0;
    return {op, 4'($urandom_range(0, 15))};
  endfunction

  task automatic tick_rand();
    ready_r = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
  endtask

  // One fetch handshake at m_pc with a given number of not-ready cycles.
  task automatic do_fetch(input int stalls, input string tag, output logic [7:0] byte_o);
    for (int i = 0; i <= stalls; i++) begin
      check_eq({tag, "_req"},  32'(bus.imem_req), 32'd1);
      check_eq({tag, "_addr"}, 32'(bus.imem_addr), 32'(m_pc));
      ready_r = (i == stalls);
      @(posedge clk);
      @(negedge clk);
    end
    byte_o = imem[m_pc];
    m_pc   = m_pc + 8'd1;
  endtask

  task automatic do_reset();
    ready_r = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_req",    32'(bus.imem_req), 32'd0);
    check_eq("rst_we",     32'(bus.rf_we), 32'd0);
    check_eq("rst_pc",     32'(pc), 32'(RST_PC));
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_z",      32'(flag_z), 32'd0);
    check_eq("rst_c",      32'(flag_c), 32'd0);
`ifdef ILLEGAL_TRAP_EN
    check_eq("rst_illegal", 32'(illegal_op), 32'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    m_pc = RST_PC;
    m_z  = 1'b0;
    m_c  = 1'b0;
  endtask

  // Execute one instruction; fix_stall < 0 selects random stalls on every fetch.
  task automatic run_instr(input int fix_stall, output bit stop_o);
    logic [7:0] ins, imm;
    logic [3:0] op;
    logic [1:0] rd, rs;
    int a, b, res, s;
    bit wr, alu, cf;
    stop_o = 1'b0;
    imm    = 8'h00;
    check_eq("pc",      32'(pc), 32'(m_pc));
    check_eq("flag_z",  32'(flag_z), 32'(m_z));
    check_eq("flag_c",  32'(flag_c), 32'(m_c));
    check_eq("running", 32'(halted), 32'd0);
    s = (fix_stall >= 0) ? fix_stall : pick_stall();
    do_fetch(s, "fetch", ins);
    op = ins[7:4];
    rd = ins[3:2];
    rs = ins[1:0];
    check_eq("decode_req", 32'(bus.imem_req), 32'd0);
    check_eq("decode_rd",  32'(bus.rf_raddr1), 32'(rd));
    check_eq("decode_rs",  32'(bus.rf_raddr2), 32'(rs));
    tick_rand();
    if (op == 4'h0 || ((op inside {[4'hC:4'hE]}) && !trap_op(op))) return;
    if (op == 4'hF || trap_op(op)) begin
      for (int i = 0; i < 4; i++) begin
        check_eq("halted",   32'(halted), 32'd1);
        check_eq("halt_req", 32'(bus.imem_req), 32'd0);
        check_eq("halt_we",  32'(bus.rf_we), 32'd0);
        check_eq("halt_pc",  32'(pc), 32'(m_pc));
`ifdef ILLEGAL_TRAP_EN
        check_eq("illegal_op", 32'(illegal_op), 32'(trap_op(op)));
`endif
        tick_rand();
      end
      stop_o = 1'b1;
      return;
    end
    if (op >= 4'h8) begin
      s = (fix_stall >= 0) ? 0 : pick_stall();
      do_fetch(s, "imm_fetch", imm);
    end
    check_eq("exec_req", 32'(bus.imem_req), 32'd0);
    check_eq("exec_we",  32'(bus.rf_we), 32'd0);
    tick_rand();
    a = m_regs[rd]; b = m_regs[rs];
    wr = 1'b1; alu = 1'b1; cf = 1'b0; res = 0;
    case (op)
      4'h1: begin res = b; alu = 1'b0; end
      4'h2: begin res = (a + b) % 256; cf = (a + b) > 255; end
      4'h3: begin res = (a - b + 256) % 256; cf = a < b; end
      4'h4: res = a & b;
      4'h5: res = a | b;
      4'h6: res = a ^ b;
      4'h7: res = 255 - b;
      4'h8: begin res = int'(imm); alu = 1'b0; end
      default: begin
        wr = 1'b0; alu = 1'b0;
        if (op == 4'h9 || (op == 4'hA && m_z) || (op == 4'hB && m_c)) m_pc = imm;
      end
    endcase
    if (alu) begin
      m_z = (res == 0);
      m_c = cf;
    end
    if (wr) begin
      check_eq("wb_we",    32'(bus.rf_we), 32'd1);
      check_eq("wb_waddr", 32'(bus.rf_waddr), 32'(rd));
      check_eq("wb_wdata", 32'(bus.rf_wdata), 32'(res));
      check_eq("wb_rd",    32'(bus.rf_raddr1), 32'(rd));
      check_eq("wb_req",   32'(bus.imem_req), 32'd0);
      m_regs[rd] = res;
      tick_rand();
    end
  endtask

  initial begin
    reset   = 1'b1;
    ready_r = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = 0;

    // Program 1: arithmetic, flags, taken JC and untaken JZ; 3-cycle stall on SUB r1,r1.
    for (int i = 0; i < 256; i++) imem[i] = 8'hF0;
    imem[8'h00] = 8'h84; imem[8'h01] = 8'h05;
    imem[8'h02] = 8'h84; imem[8'h03] = 8'hF0;
    imem[8'h04] = 8'h88; imem[8'h05] = 8'h20;
    imem[8'h06] = 8'h26;
    imem[8'h07] = 8'h35;
    imem[8'h08] = 8'h80; imem[8'h09] = 8'h03;
    imem[8'h0A] = 8'h84; imem[8'h0B] = 8'h05;
    imem[8'h0C] = 8'h31;
    imem[8'h0D] = 8'hB0; imem[8'h0E] = 8'h40;
    imem[8'h40] = 8'hA0; imem[8'h41] = 8'h40;
    imem[8'h42] = 8'hF0;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      run_instr((k == 4) ? 3 : 0, stop);
      if (stop) break;
    end
    check_eq("p1_r0",      32'(rf_mem[0]), 32'hFE);
    check_eq("p1_r1",      32'(rf_mem[1]), 32'h05);
    check_eq("p1_r2",      32'(rf_mem[2]), 32'h20);
    check_eq("p1_halt_pc", 32'(pc), 32'h43);

    // Program 2: reset during MOV writeback, then illegal opcode C0 and HALT.
    for (int i = 0; i < 256; i++) imem[i] = 8'hF0;
    imem[0] = 8'h8C; imem[1] = 8'h5A;
    imem[2] = 8'h88; imem[3] = 8'h77;
    imem[4] = 8'h1E;
    imem[5] = 8'hC0;
    imem[6] = 8'hF0;
    do_reset();
    run_instr(0, stop);
    run_instr(0, stop);
    do_fetch(0, "mov_fetch", tmp_byte);
    tick_rand();
    tick_rand();
    check_eq("mov_wb_we",    32'(bus.rf_we), 32'd1);
    check_eq("mov_wb_wdata", 32'(bus.rf_wdata), 32'h77);
    reset = 1'b1;
    #1;
    check_eq("rst_gates_we", 32'(bus.rf_we), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_r3_kept",  32'(rf_mem[3]), 32'h5A);
    check_eq("rst_wb_pc",    32'(pc), 32'(RST_PC));
    check_eq("rst_wb_req",   32'(bus.imem_req), 32'd1);
    check_eq("rst_wb_addr",  32'(bus.imem_addr), 32'(RST_PC));
    m_pc = RST_PC; m_z = 1'b0; m_c = 1'b0;
    for (int k = 0; k < 10; k++) begin
      run_instr(0, stop);
      if (stop) break;
    end
    check_eq("p2_r3", 32'(rf_mem[3]), 32'h77);
    check_eq("p2_halt_pc", 32'(pc), TRAP_EN ? 32'h06 : 32'h07);

    // Random programs with random stalls; first four instructions seed all registers.
    for (int i = 0; i < 256; i++) imem[i] = rand_byte();
    for (int r = 0; r < 4; r++) begin
      imem[2*r]   = {4'h8, 2'(r), 2'b00};
      imem[2*r+1] = 8'($urandom_range(0, 255));
    end
    do_reset();
    for (int k = 0; k < 600; k++) begin
      run_instr(-1, stop);
      if (stop) break;
    end
    for (int r = 0; r < 4; r++) check_eq("final_reg", 32'(rf_mem[r]), 32'(m_regs[r]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
